// File: rtl/time_set_rx_pkg.sv
// Shared constants and types for the serial time-set receiver.
// Holds the ASCII frame characters, FSM encodings and the bit-period derivation.
package time_set_rx_pkg;

  localparam logic [7:0] CH_T  = 8'h54;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;

  typedef enum logic [2:0] {
    P_IDLE = 3'd0,
    H1     = 3'd1,
    H0     = 3'd2,
    M1     = 3'd3,
    M0     = 3'd4,
    S1     = 3'd5,
    S0     = 3'd6,
    P_CR   = 3'd7
  } p_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  function automatic int div_calc(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/time_set_if.sv
// Time-set result bus: BCD time fields plus LOAD/ERR strobes and BUSY.
// The receiver drives it through the master modport; time counters read it as slave.
interface time_set_if;
  logic [1:0] HOURH;
  logic [3:0] HOURL;
  logic [2:0] MINH;
  logic [3:0] MINL;
  logic [2:0] SECH;
  logic [3:0] SECL;
  logic       LOAD;
  logic       ERR;
  logic       BUSY;

  modport master (output HOURH, HOURL, MINH, MINL, SECH, SECL, LOAD, ERR, BUSY);
  modport slave  (input  HOURH, HOURL, MINH, MINL, SECH, SECL, LOAD, ERR, BUSY);
endinterface

// File: rtl/time_set_rx_uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop synchronizer, mid-bit sampling timer and byte FSM.
// Emits byte_valid or frame_err as one-cycle strobes after the stop-bit sample.
module uart_rx_byte
  import time_set_rx_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int DIV  = div_calc(CLK_FREQ, BAUD);
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  logic            sync1_r, sync2_r, prev_r;
  logic            fall_s;
  rx_state_t       state_r;
  logic [CW-1:0]   cnt_r;
  logic [2:0]      bit_r;
  logic [7:0]      shift_r;
  logic            byte_valid_r, frame_err_r;

  // Synchronizer and edge-history flops; reset high so a start bit needs a prior idle line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= rxd;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign fall_s = prev_r & ~sync2_r;

  // Byte receiver FSM with bit timer; START re-checks the line to reject glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= RX_IDLE;
      cnt_r        <= {CW{1'b0}};
      bit_r        <= 3'd0;
      shift_r      <= 8'h00;
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      case (state_r)
        RX_IDLE: begin
          cnt_r <= {CW{1'b0}};
          if (fall_s) state_r <= RX_START;
        end
        RX_START: begin
          if (cnt_r == HALF_LAST) begin
            cnt_r   <= {CW{1'b0}};
            bit_r   <= 3'd0;
            state_r <= sync2_r ? RX_IDLE : RX_DATA;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_r == DIV_LAST) begin
            cnt_r   <= {CW{1'b0}};
            shift_r <= {sync2_r, shift_r[7:1]};
            bit_r   <= bit_r + 3'd1;
            if (bit_r == 3'd7) state_r <= RX_STOP;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_r == DIV_LAST) begin
            cnt_r        <= {CW{1'b0}};
            byte_valid_r <= sync2_r;
            frame_err_r  <= ~sync2_r;
            state_r      <= RX_IDLE;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        default: state_r <= RX_IDLE;
      endcase
    end
  end

  assign byte_valid = byte_valid_r;
  assign frame_err  = frame_err_r;
  assign rx_byte    = shift_r;

endmodule

// File: rtl/time_set_rx.sv
// Serial time-set receiver: parses "Thhmmss<CR>" frames from the UART byte stream
// and presents a validated 24-hour BCD time with LOAD, or pulses ERR on a bad frame.
module time_set_rx
  import time_set_rx_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         RXD,
  time_set_if.master   tif
);

  logic       byte_valid_s, frame_err_s;
  logic [7:0] rx_byte_s;

  uart_rx_byte #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
    .clk        (CLK),
    .rst_n      (RST),
    .rxd        (RXD),
    .byte_valid (byte_valid_s),
    .rx_byte    (rx_byte_s),
    .frame_err  (frame_err_s)
  );

  p_state_t   p_state_r, nxt_s;
  logic       is_digit_s, digit_ok_s;
  logic [3:0] dval_s;

  logic [1:0] sh_hh_r;
  logic [3:0] sh_hl_r, sh_ml_r, sh_sl_r;
  logic [2:0] sh_mh_r, sh_sh_r;

  logic [1:0] hourh_r;
  logic [3:0] hourl_r, minl_r, secl_r;
  logic [2:0] minh_r, sech_r;
  logic       load_r, err_r, busy_r;

  // Digit classification and range rule for the digit the parser currently expects.
  always_comb begin
    is_digit_s = (rx_byte_s >= CH_0) && (rx_byte_s <= CH_9);
    dval_s     = rx_byte_s[3:0];  // ASCII '0'-'9' low nibble is the digit value
    digit_ok_s = 1'b0;
    nxt_s      = P_IDLE;
    case (p_state_r)
      H1: begin digit_ok_s = is_digit_s && (dval_s <= 4'd2); nxt_s = H0; end
      H0: begin digit_ok_s = is_digit_s && ((sh_hh_r != 2'd2) || (dval_s <= 4'd3)); nxt_s = M1; end
      M1: begin digit_ok_s = is_digit_s && (dval_s <= 4'd5); nxt_s = M0; end
      M0: begin digit_ok_s = is_digit_s; nxt_s = S1; end
      S1: begin digit_ok_s = is_digit_s && (dval_s <= 4'd5); nxt_s = S0; end
      S0: begin digit_ok_s = is_digit_s; nxt_s = P_CR; end
      default: begin digit_ok_s = 1'b0; nxt_s = P_IDLE; end
    endcase
  end

  // Frame parser with shadow digits and registered outputs; 'T' always restarts a frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p_state_r <= P_IDLE;
      sh_hh_r <= 2'd0; sh_hl_r <= 4'd0; sh_mh_r <= 3'd0;
      sh_ml_r <= 4'd0; sh_sh_r <= 3'd0; sh_sl_r <= 4'd0;
      hourh_r <= 2'd0; hourl_r <= 4'd0; minh_r  <= 3'd0;
      minl_r  <= 4'd0; sech_r  <= 3'd0; secl_r  <= 4'd0;
      load_r  <= 1'b0; err_r   <= 1'b0; busy_r  <= 1'b0;
    end else begin
      load_r <= 1'b0;
      err_r  <= 1'b0;
      if (frame_err_s) begin
        if (p_state_r != P_IDLE) begin
          err_r     <= 1'b1;
          busy_r    <= 1'b0;
          p_state_r <= P_IDLE;
        end
      end else if (byte_valid_s) begin
        if (rx_byte_s == CH_T) begin
          p_state_r <= H1;
          busy_r    <= 1'b1;
        end else begin
          case (p_state_r)
            P_IDLE: p_state_r <= P_IDLE;
            P_CR: begin
              if (rx_byte_s == CH_CR) begin
                hourh_r <= sh_hh_r; hourl_r <= sh_hl_r; minh_r <= sh_mh_r;
                minl_r  <= sh_ml_r; sech_r  <= sh_sh_r; secl_r <= sh_sl_r;
                load_r  <= 1'b1;
              end else begin
                err_r <= 1'b1;
              end
              busy_r    <= 1'b0;
              p_state_r <= P_IDLE;
            end
            default: begin
              if (digit_ok_s) begin
                p_state_r <= nxt_s;
                case (p_state_r)
                  H1:      sh_hh_r <= dval_s[1:0];
                  H0:      sh_hl_r <= dval_s;
                  M1:      sh_mh_r <= dval_s[2:0];
                  M0:      sh_ml_r <= dval_s;
                  S1:      sh_sh_r <= dval_s[2:0];
                  default: sh_sl_r <= dval_s;
                endcase
              end else begin
                err_r     <= 1'b1;
                busy_r    <= 1'b0;
                p_state_r <= P_IDLE;
              end
            end
          endcase
        end
      end
    end
  end

  assign tif.HOURH = hourh_r;
  assign tif.HOURL = hourl_r;
  assign tif.MINH  = minh_r;
  assign tif.MINL  = minl_r;
  assign tif.SECH  = sech_r;
  assign tif.SECL  = secl_r;
  assign tif.LOAD  = load_r;
  assign tif.ERR   = err_r;
  assign tif.BUSY  = busy_r;

endmodule

// File: tb/tb_time_set_rx.sv
// Bench for time_set_rx: table of frames plus hand-built corner sequences,
// with LOAD/ERR events checked against a queue of expected events.
module tb_time_set_rx;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 3_125_000;
  localparam int DIV      = CLK_FREQ / BAUD;

  localparam logic [1:0] K_NONE = 2'b00;
  localparam logic [1:0] K_LOAD = 2'b10;
  localparam logic [1:0] K_ERR  = 2'b01;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rxd = 1'b1;

  always #10 clk = ~clk;

  time_set_if tif();

  time_set_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .CLK (clk),
    .RST (rst),
    .RXD (rxd),
    .tif (tif)
  );

  typedef struct {
    logic [1:0]  kind;
    logic [19:0] t;
  } ev_t;

  typedef struct {
    logic [127:0] txt;
    int           len;
    logic [1:0]   kind;
    logic [19:0]  t;
  } vec_t;

  ev_t         sb[$];
  vec_t        vecs[$];
  ev_t         mon_e;
  int          n_vec = 0;
  int          n_miss = 0;
  int          n_events = 0;
  logic [19:0] held = 20'h0;
  logic [19:0] dut_t;

  assign dut_t = {tif.HOURH, tif.HOURL, tif.MINH, tif.MINL, tif.SECH, tif.SECL};

  function automatic logic [19:0] tm(input int h, input int m, input int s);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string s, input logic [1:0] k, input logic [19:0] t);
    vec_t v;
    v.txt = 128'h0;
    for (int i = 0; i < s.len(); i++) v.txt[8*i +: 8] = s[i];
    v.len  = s.len();
    v.kind = k;
    v.t    = t;
    vecs.push_back(v);
  endtask

  task automatic exp_load(input logic [19:0] t);
    sb.push_back('{K_LOAD, t});
    held = t;
  endtask

  task automatic exp_err();
    sb.push_back('{K_ERR, held});
  endtask

  task automatic send_bits(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = stop;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    logic [7:0] b;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      send_bits(b, 1'b1);
      if (b == 8'h54) chk("busy_after_T", 32'(tif.BUSY), 32'd1);
    end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 20 * DIV) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (2 * DIV) @(negedge clk);
  endtask

  // Scoreboard monitor: every LOAD/ERR strobe must match the oldest expected event.
  always @(negedge clk) begin
    if (rst && (tif.LOAD || tif.ERR)) begin
      n_events++;
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_event: got LOAD=%0b ERR=%0b, expected none", tif.LOAD, tif.ERR);
      end else begin
        mon_e = sb.pop_front();
        chk("event_kind", 32'({tif.LOAD, tif.ERR}), 32'(mon_e.kind));
        chk("event_time", 32'(dut_t), 32'(mon_e.t));
        chk("busy_at_event", 32'(tif.BUSY), 32'd0);
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got no finish, expected finish before 3 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t cv;
    logic [7:0] b;
    int ev0;

    add_vec("T235959\015",    K_LOAD, tm(23, 59, 59));
    add_vec("T240000\015",    K_ERR,  20'h0);
    add_vec("T12T083000\015", K_LOAD, tm(8, 30, 0));
    add_vec("T196000\015",    K_ERR,  20'h0);
    add_vec("T200000\015",    K_LOAD, tm(20, 0, 0));
    add_vec("T0X",            K_ERR,  20'h0);
    add_vec("T2\015",         K_ERR,  20'h0);
    add_vec("T3",             K_ERR,  20'h0);
    add_vec("T150739\015",    K_LOAD, tm(15, 7, 39));
    add_vec("T095960\015",    K_ERR,  20'h0);
    add_vec("AB\015",         K_NONE, 20'h0);

    repeat (5) @(negedge clk);
    chk("reset_time", 32'(dut_t), 32'd0);
    chk("reset_flags", 32'({tif.LOAD, tif.ERR, tif.BUSY}), 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    for (int v = 0; v < vecs.size(); v++) begin
      cv = vecs[v];
      if (cv.kind == K_LOAD) exp_load(cv.t);
      else if (cv.kind == K_ERR) exp_err();
      for (int i = 0; i < cv.len; i++) begin
        b = cv.txt[8*i +: 8];
        send_bits(b, 1'b1);
        if (b == 8'h54) chk("busy_after_T", 32'(tif.BUSY), 32'd1);
      end
      drain("vec_drain");
      chk("busy_idle", 32'(tif.BUSY), 32'd0);
      chk("held_time", 32'(dut_t), 32'(held));
    end

    // Stop bit held low mid-frame aborts it; a clean frame afterwards still loads.
    send_str("T1200");
    exp_err();
    send_bits(8'h35, 1'b0);
    rxd = 1'b1;
    drain("framing_drain");
    chk("framing_busy", 32'(tif.BUSY), 32'd0);
    exp_load(tm(0, 0, 0));
    send_str("T000000\015");
    drain("after_framing_drain");
    chk("after_framing_time", 32'(dut_t), 32'(held));

    // Short low glitch on the idle line followed by junk: nothing happens.
    ev0 = n_events;
    @(negedge clk);
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    send_str("AB\015");
    repeat (2 * DIV) @(negedge clk);
    chk("glitch_quiet", 32'(n_events), 32'(ev0));
    chk("glitch_busy", 32'(tif.BUSY), 32'd0);

    // Reset in the middle of the minute digits, then resend the whole frame.
    exp_load(tm(23, 59, 59));
    send_str("T235959\015");
    drain("pre_reset_drain");
    send_str("T10");
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    rst = 1'b0;
    held = 20'h0;
    repeat (2) @(negedge clk);
    chk("midreset_time", 32'(dut_t), 32'd0);
    chk("midreset_flags", 32'({tif.LOAD, tif.ERR, tif.BUSY}), 32'd0);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    exp_load(tm(10, 10, 10));
    send_str("T101010\015");
    drain("resend_drain");
    chk("resend_time", 32'(dut_t), 32'(tm(10, 10, 10)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
